// File: rtl/kanagawa_fifo_read_adapter.sv
// Read-side FIFO consumer: credit-tracked rdreq issue, latency-matched capture, valid/ready output.
// Define KANAGAWA_FIFO_READ_ADAPTER_STATS_EN to add the read and stall counters.
module kanagawa_fifo_read_adapter #(
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 2,
  parameter int OUT_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             rdreq_out,
  input  logic             empty_in,
  input  logic [WIDTH-1:0] rddata_in,
  input  logic             flush_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy_out
`ifdef KANAGAWA_FIFO_READ_ADAPTER_STATS_EN
  ,
  output logic [31:0]      reads_out,
  output logic [31:0]      stall_cycles_out
`endif
);

  localparam int CW = $clog2(OUT_DEPTH + 1) + 1;
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic {
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [READ_LATENCY-1:0] inflight;
  logic [READ_LATENCY-1:0] inflight_nxt;
  logic [WIDTH-1:0]        mem [OUT_DEPTH];
  logic [PW-1:0]           head, head_nxt;
  logic [PW-1:0]           tail, tail_nxt;
  logic [CW-1:0]           count, count_nxt;
  logic [CW-1:0]           inflight_cnt;
  logic [CW-1:0]           occupancy;
  logic                    pop;
  logic                    capture;
  logic                    clear;
  logic                    inc;
  logic                    dec;

  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CW'(inflight[i]);
    end
  end

  assign valid_out = (count != '0) && (state == RUN);
  assign data_out  = mem[head];
  assign pop       = valid_out && ready_in;
  assign clear     = flush_in && (state == RUN);
  assign capture   = inflight[READ_LATENCY-1] && (state == RUN) && !flush_in;

  // a same-cycle pop frees its slot for the request issued now
  assign occupancy = count + inflight_cnt - CW'(pop);

  assign rdreq_out = rst_n && (state == RUN) && !empty_in && !flush_in &&
                     (occupancy < CW'(OUT_DEPTH));

  assign inflight_nxt = (inflight << 1) | READ_LATENCY'(rdreq_out);

  assign inc = capture && !pop && !clear;
  assign dec = pop && !capture && !clear;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      clear:   count_nxt = '0;
      inc:     count_nxt = count + CW'(1);
      dec:     count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    if (clear) begin
      head_nxt = '0;
      tail_nxt = '0;
    end else begin
      if (pop) begin
        head_nxt = adv(head);
      end
      if (capture) begin
        tail_nxt = adv(tail);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    unique case (state)
      RUN: begin
        if (flush_in && (|inflight)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy_out = 1'b1;
        if (~|inflight) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      inflight <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      count    <= count_nxt;
      head     <= head_nxt;
      tail     <= tail_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (capture) begin
      mem[tail] <= rddata_in;
    end
  end

`ifdef KANAGAWA_FIFO_READ_ADAPTER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reads_out        <= '0;
      stall_cycles_out <= '0;
    end else if (flush_in) begin
      reads_out        <= '0;
      stall_cycles_out <= '0;
    end else begin
      if (rdreq_out) begin
        reads_out <= reads_out + 32'd1;
      end
      if (valid_out && !ready_in && (stall_cycles_out != '1)) begin
        stall_cycles_out <= stall_cycles_out + 32'd1;
      end
    end
  end
`endif

endmodule
